// File: rtl/keypad_operand_loader_pkg.sv
// Shared types and constants for the keypad operand loader.
// Operands are four hex digits wide, so one operand fills a 16-bit half-precision word.
package keypad_operand_loader_pkg;

  localparam int unsigned OPERAND_WIDTH      = 16;
  localparam int unsigned DIGIT_WIDTH        = 4;
  localparam int unsigned DIGITS_PER_OPERAND = 4;

  typedef enum logic [1:0] {
    StLoadA = 2'd0,
    StLoadB = 2'd1,
    StIssue = 2'd2
  } state_e;

endpackage

// File: rtl/keypad_operand_loader_debounce.sv
// Key debouncer: emits one press_event per accepted press and re-arms only after an
// accepted release. Both the press and the release must be stable for DB_CYCLES cycles.
module key_debounce #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_hit,
  output logic press_event
);

  localparam logic [15:0] DbLimit = 16'(DB_CYCLES);

  logic        level_q, level_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pressed_q, pressed_d;
  logic [15:0] run_len;

  // run_len counts this cycle too, so the event fires on the DB_CYCLES-th high sample.
  always_comb begin
    if (key_hit != level_q) begin
      run_len = 16'd1;
    end else if (cnt_q == 16'hFFFF) begin
      run_len = cnt_q;
    end else begin
      run_len = cnt_q + 16'd1;
    end

    level_d     = key_hit;
    cnt_d       = run_len;
    pressed_d   = pressed_q;
    press_event = 1'b0;

    if (key_hit && !pressed_q && (run_len >= DbLimit)) begin
      press_event = 1'b1;
      pressed_d   = 1'b1;
    end else if (!key_hit && pressed_q && (run_len >= DbLimit)) begin
      pressed_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q   <= 1'b0;
      cnt_q     <= 16'd0;
      pressed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
    end
  end

endmodule

// File: rtl/keypad_operand_loader.sv
// Collects two 4-digit hex operands from a debounced keypad and offers them to an adder
// with a valid/ready handshake.
module keypad_operand_loader
  import keypad_operand_loader_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_hit,
  input  logic [3:0]  key_code,
  input  logic        key_clear,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] entry,
  output logic [1:0]  digit_cnt,
  output logic        loading_b
);

  localparam logic [1:0] LastDigit = 2'(DIGITS_PER_OPERAND - 1);

  state_e                     state_q, state_d;
  logic [OPERAND_WIDTH-1:0]   op_a_q, op_a_d;
  logic [OPERAND_WIDTH-1:0]   op_b_q, op_b_d;
  logic [OPERAND_WIDTH-1:0]   entry_q, entry_d;
  logic [1:0]                 digit_cnt_q, digit_cnt_d;
  logic                       op_valid_q, op_valid_d;
  logic [OPERAND_WIDTH-1:0]   shifted;
  logic                       press_event;

  key_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .key_hit     (key_hit),
    .press_event (press_event)
  );

  assign shifted = {entry_q[OPERAND_WIDTH-DIGIT_WIDTH-1:0], key_code};

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    entry_d     = entry_q;
    digit_cnt_d = digit_cnt_q;
    op_valid_d  = op_valid_q;

    unique case (state_q)
      StLoadA, StLoadB: begin
        // Clear has priority over a digit arriving in the same cycle.
        if (key_clear) begin
          entry_d     = '0;
          digit_cnt_d = '0;
          state_d     = StLoadA;
        end else if (press_event) begin
          if (digit_cnt_q == LastDigit) begin
            entry_d     = '0;
            digit_cnt_d = '0;
            if (state_q == StLoadA) begin
              op_a_d  = shifted;
              state_d = StLoadB;
            end else begin
              op_b_d     = shifted;
              op_valid_d = 1'b1;
              state_d    = StIssue;
            end
          end else begin
            entry_d     = shifted;
            digit_cnt_d = digit_cnt_q + 2'd1;
          end
        end
      end
      StIssue: begin
        if (op_valid_q && op_ready) begin
          op_valid_d = 1'b0;
          state_d    = StLoadA;
        end
      end
      default: begin
        state_d    = StLoadA;
        op_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StLoadA;
      op_a_q      <= '0;
      op_b_q      <= '0;
      entry_q     <= '0;
      digit_cnt_q <= '0;
      op_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      entry_q     <= entry_d;
      digit_cnt_q <= digit_cnt_d;
      op_valid_q  <= op_valid_d;
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = op_valid_q;
  assign entry     = entry_q;
  assign digit_cnt = digit_cnt_q;
  assign loading_b = (state_q == StLoadB);

endmodule

// File: tb/tb_keypad_operand_loader.sv
// Bench for keypad_operand_loader: a behavioural digit-entry model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_keypad_operand_loader;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_hit;
  logic [3:0]  key_code;
  logic        key_clear;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] entry;
  logic [1:0]  digit_cnt;
  logic        loading_b;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;

  keypad_operand_loader #(
    .DB_CYCLES (DB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_hit   (key_hit),
    .key_code  (key_code),
    .key_clear (key_clear),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .entry     (entry),
    .digit_cnt (digit_cnt),
    .loading_b (loading_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = typing A, 1 = typing B, 2 = operands offered.
  int   m_prev, m_run, m_armed, m_phase, m_entry, m_cnt, m_a, m_b;
  logic m_ev;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev = 0; m_run = 0; m_armed = 1;
      m_phase = 0; m_entry = 0; m_cnt = 0; m_a = 0; m_b = 0;
    end else begin
      m_ev = 1'b0;
      m_run = (int'(key_hit) == m_prev) ? m_run + 1 : 1;
      m_prev = int'(key_hit);
      if (key_hit && m_armed == 1 && m_run >= DB) begin
        m_ev = 1'b1;
        m_armed = 0;
      end else if (!key_hit && m_armed == 0 && m_run >= DB) begin
        m_armed = 1;
      end
      if (m_phase == 2) begin
        if (op_ready) m_phase = 0;
      end else if (key_clear) begin
        m_entry = 0; m_cnt = 0; m_phase = 0;
      end else if (m_ev) begin
        m_entry = (m_entry * 16 + int'(key_code)) % 65536;
        m_cnt++;
        if (m_cnt == 4) begin
          if (m_phase == 0) m_a = m_entry;
          else m_b = m_entry;
          m_phase++;
          m_entry = 0;
          m_cnt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("op_a", op_a, 16'(m_a));
    chk("op_b", op_b, 16'(m_b));
    chk("op_valid", {15'd0, op_valid}, {15'd0, m_phase == 2});
    chk("entry", entry, 16'(m_entry));
    chk("digit_cnt", {14'd0, digit_cnt}, 16'(m_cnt));
    chk("loading_b", {15'd0, loading_b}, {15'd0, m_phase == 1});
    if (op_valid) valid_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    key_code = c;
    key_hit  = 1'b1;
    tick(DB + 2);
    key_hit  = 1'b0;
    tick(DB + 2);
  endtask

  int  v0;
  bit  seen;

  initial begin
    rst = 1'b1; key_hit = 1'b0; key_code = 4'h0; key_clear = 1'b0; op_ready = 1'b1;
    tick(2);
    chk("rst_op_a", op_a, 16'h0000);
    chk("rst_entry", entry, 16'h0000);
    chk("rst_valid", {15'd0, op_valid}, 16'd0);
    rst = 1'b0;
    tick(2);

    // Basic load.
    press(4'h3); press(4'hC); press(4'h0); press(4'h0);
    chk("basic_op_a", op_a, 16'h3C00);
    chk("basic_in_b", {15'd0, loading_b}, 16'd1);
    v0 = valid_cycles;
    press(4'h4); press(4'h0); press(4'h0); press(4'h0);
    chk("basic_op_b", op_b, 16'h4000);
    chk("basic_pulses", 16'(valid_cycles - v0), 16'd1);
    chk("basic_back_a", {15'd0, loading_b | op_valid}, 16'd0);

    // Bounce then hold.
    key_code = 4'h7;
    repeat (5) begin
      key_hit = 1'b1; tick(2);
      key_hit = 1'b0; tick(2);
    end
    chk("bounce_none", {14'd0, digit_cnt}, 16'd0);
    key_hit = 1'b1;
    tick(100);
    chk("hold_cnt", {14'd0, digit_cnt}, 16'd1);
    chk("hold_entry", entry, 16'h0007);
    key_hit = 1'b0;
    tick(DB + 2);
    key_clear = 1'b1; tick(1); key_clear = 1'b0; tick(1);

    // Backpressure, with a press discarded while operands are offered.
    op_ready = 1'b0;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    press(4'h5); press(4'h6); press(4'h7);
    key_code = 4'h8; key_hit = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1);
      seen = op_valid;
    end
    chk("bp_valid_rise", {15'd0, seen}, 16'd1);
    key_hit = 1'b0; key_code = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) key_hit = 1'b1;
      tick(1);
      chk("bp_hold_valid", {15'd0, op_valid}, 16'd1);
      chk("bp_hold_a", op_a, 16'h1234);
      chk("bp_hold_b", op_b, 16'h5678);
    end
    op_ready = 1'b1;
    tick(1);
    chk("bp_done", {15'd0, op_valid}, 16'd0);
    key_hit = 1'b0;
    tick(DB + 2);
    chk("bp_discard", {14'd0, digit_cnt}, 16'd0);

    // Clear mid-entry.
    press(4'h1); press(4'h2);
    chk("clr_before", entry, 16'h0012);
    key_clear = 1'b1; tick(1); key_clear = 1'b0;
    chk("clr_after", entry, 16'h0000);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8);
    chk("clr_op_a", op_a, 16'h5678);

    // Clear and press event on the same edge.
    press(4'h9);
    chk("same_pre", {14'd0, digit_cnt}, 16'd1);
    key_code = 4'h7; key_hit = 1'b1;
    tick(DB - 1);
    key_clear = 1'b1; tick(1); key_clear = 1'b0;
    chk("same_entry", entry, 16'h0000);
    chk("same_cnt", {14'd0, digit_cnt}, 16'd0);
    chk("same_state", {15'd0, loading_b}, 16'd0);
    key_hit = 1'b0;
    tick(DB + 2);

    // Reset mid-entry.
    press(4'hA); press(4'hB); press(4'hC); press(4'hD);
    press(4'h1); press(4'h2);
    chk("mid_entry", entry, 16'h0012);
    rst = 1'b1; #1;
    chk("mid_rst_a", op_a, 16'h0000);
    chk("mid_rst_entry", entry, 16'h0000);
    chk("mid_rst_b", {15'd0, loading_b}, 16'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    v0 = valid_cycles;
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    press(4'h5); press(4'h4); press(4'h3); press(4'h2);
    chk("fresh_a", op_a, 16'h9876);
    chk("fresh_b", op_b, 16'h5432);
    chk("fresh_pulses", 16'(valid_cycles - v0), 16'd1);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
